// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seg7_pkg
//  Description : Shared constants for the seven-segment display drivers.
//                SEG_LUT holds the active-low codes for hex digits 0..F with
//                the decimal point off (bit 7 = dp, bits 6:0 = g..a).
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Index 15 is listed first so that SEG_LUT[nibble] selects the code.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h98, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Interface   : seg7_scan_driver_if
//  Description : Display-register side and pin side of the scan driver.
//                master = register/datapath block driving the display,
//                slave  = seg7_scan_driver.
//  Signals     : value_i  [4*NUM_DIGITS] hex nibbles, nibble k -> digit k
//                dp_i     [NUM_DIGITS]   decimal point per digit
//                blank_i  [NUM_DIGITS]   force digit dark
//                blink_i  [NUM_DIGITS]   digit blinks
//                lzb_en_i                leading-zero blanking enable
//                load_i                  capture all inputs into pending set
//                an_o     [NUM_DIGITS]   anode enables
//                seg_o    [8]            active-low segments, bit 7 = dp
//                frame_o                 one-cycle pulse at frame start
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic [NUM_DIGITS-1:0]   blink_i;
    logic                    lzb_en_i;
    logic                    load_i;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [7:0]              seg_o;
    logic                    frame_o;

    modport master (
        output value_i, dp_i, blank_i, blink_i, lzb_en_i, load_i,
        input  an_o, seg_o, frame_o
    );

    modport slave (
        input  value_i, dp_i, blank_i, blink_i, lzb_en_i, load_i,
        output an_o, seg_o, frame_o
    );
endinterface : seg7_scan_driver_if
`default_nettype wire

// File: rtl/seg7_hex_lut.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_lut
//  Description : Combinational hex nibble + decimal point to active-low
//                seven-segment code.
//  Ports       : i_nibble [4]  hex digit 0..F
//                i_dp          decimal point on
//                o_seg    [8]  active-low code, bit 7 = dp, bits 6:0 = g..a
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_LUT[i_nibble];
        if (i_dp) begin
            o_seg[DP_BIT] = 1'b0;
        end
    end

endmodule : seg7_hex_lut
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Multiplexed NUM_DIGITS seven-segment driver. Inputs are
//                captured into a pending set on load_i and copied to the
//                display set at each frame boundary, so a frame always shows
//                one coherent snapshot. One shared segment bus is scanned
//                across the anode enables, CLK_DIV clocks per digit, with
//                the first clock of each slot dark to avoid ghosting.
//  Ports       : clk   system clock
//                rst   asynchronous active-high reset
//                bus   seg7_scan_driver_if.slave (inputs, an_o/seg_o/frame_o)
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int CLK_DIV       = 100000,
    parameter int BLINK_DIV     = 64,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0]      C_CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      C_IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FCNT_W-1:0]     C_FCNT_MAX = FCNT_W'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = AN_ACTIVE_LOW ?
                                                   {NUM_DIGITS{1'b1}} :
                                                   {NUM_DIGITS{1'b0}};

    // Scan counters and blink state
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [FCNT_W-1:0]       r_fcnt;
    logic                    r_phase;

    // Pending register set
    logic [4*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic                    r_pend_lzb;

    // Display register set
    logic [4*NUM_DIGITS-1:0] r_disp_value;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_blank;
    logic [NUM_DIGITS-1:0]   r_disp_blink;
    logic                    r_disp_lzb;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;
    logic                    r_frame;

    logic                    w_tick;
    logic                    w_commit;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank;
    logic                    w_blink;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_lz_run;
    logic                    w_lz_sel;
    logic                    w_dark;
    logic [7:0]              w_code;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_an_on;

    assign w_tick   = (r_cnt == C_CNT_MAX);
    assign w_commit = w_tick && (r_idx == C_IDX_MAX);

    // ------------------------------------------------------------------
    // Prescaler, digit index and blink phase
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == C_IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Frame count advances only on commit, so the phase can never
            // change in the middle of a frame.
            if (w_commit) begin
                if (r_fcnt == C_FCNT_MAX) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending / display double buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_blink <= '0;
            r_pend_lzb   <= 1'b0;
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_disp_blink <= '0;
            r_disp_lzb   <= 1'b0;
        end else begin
            if (bus.load_i) begin
                r_pend_value <= bus.value_i;
                r_pend_dp    <= bus.dp_i;
                r_pend_blank <= bus.blank_i;
                r_pend_blink <= bus.blink_i;
                r_pend_lzb   <= bus.lzb_en_i;
            end
            // A load landing on the commit tick bypasses the pending set
            // so it is shown in the frame that starts immediately.
            if (w_commit) begin
                if (bus.load_i) begin
                    r_disp_value <= bus.value_i;
                    r_disp_dp    <= bus.dp_i;
                    r_disp_blank <= bus.blank_i;
                    r_disp_blink <= bus.blink_i;
                    r_disp_lzb   <= bus.lzb_en_i;
                end else begin
                    r_disp_value <= r_pend_value;
                    r_disp_dp    <= r_pend_dp;
                    r_disp_blank <= r_pend_blank;
                    r_disp_blink <= r_pend_blink;
                    r_disp_lzb   <= r_pend_lzb;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Current digit select
    // ------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        w_dp     = 1'b0;
        w_blank  = 1'b0;
        w_blink  = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_disp_value[4*k +: 4];
                w_dp        = r_disp_dp[k];
                w_blank     = r_disp_blank[k];
                w_blink     = r_disp_blink[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Leading-zero blanking: walk from the most significant digit down,
    // keeping a running "everything at or above here is 0 with no dp".
    // Digit 0 is excluded so a zero value still shows one '0'.
    always_comb begin
        w_lz_run = 1'b1;
        w_lz_sel = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_lz_run = w_lz_run & (r_disp_value[4*k +: 4] == 4'h0) & ~r_disp_dp[k];
            if ((k > 0) && (r_idx == IDX_W'(k))) begin
                w_lz_sel = w_lz_run & r_disp_lzb;
            end
        end
    end

    seg7_hex_lut u_hex_lut (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_code)
    );

    assign w_dark     = w_blank | w_lz_sel | (w_blink & r_phase);
    assign w_seg_next = w_dark ? SEG_BLANK : w_code;
    assign w_an_on    = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;

    // ------------------------------------------------------------------
    // Output registers: one cycle behind the counters. Anodes are held
    // off for the cycle after cnt==0 so the segment bus settles on the
    // new digit before it is lit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an    <= C_AN_OFF;
            r_seg   <= SEG_BLANK;
            r_frame <= 1'b0;
        end else begin
            r_an    <= (r_cnt == '0) ? C_AN_OFF : w_an_on;
            r_seg   <= w_seg_next;
            r_frame <= w_commit;
        end
    end

    assign bus.an_o    = r_an;
    assign bus.seg_o   = r_seg;
    assign bus.frame_o = r_frame;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver (4 digits,
//                CLK_DIV=4, BLINK_DIV=2, active-low anodes).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int CD    = 4;
    localparam int BD    = 2;
    localparam int FRAME = CD * ND;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS    (ND),
        .CLK_DIV       (CD),
        .BLINK_DIV     (BD),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic        lzb;
    } set_t;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: n = clock edges since reset released (== counter state)
    set_t       m_pend, m_disp, m_in;
    int         n;
    int         m_cnt, m_idx;
    logic       m_ph;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_frame;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] model_seg(input set_t s, input int k, input logic ph);
        logic [7:0] code;
        logic       lz;
        code = seg_tab[s.value[4*k +: 4]];
        if (s.dp[k]) code[7] = 1'b0;
        lz = 1'b0;
        if (s.lzb && k > 0) begin
            lz = 1'b1;
            for (int j = k; j < ND; j++)
                if (s.value[4*j +: 4] != 4'h0 || s.dp[j]) lz = 1'b0;
        end
        if (s.blank[k] || lz || (s.blink[k] && ph)) code = 8'hFF;
        return code;
    endfunction

    // Model: expected outputs after each edge, from the cycle count
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0; m_pend = '0; m_disp = '0;
                exp_an = 4'hF; exp_seg = 8'hFF; exp_frame = 1'b0;
            end else begin
                m_cnt     = n % CD;
                m_idx     = (n / CD) % ND;
                m_ph      = (((n / FRAME) / BD) % 2) == 1;
                exp_an    = (m_cnt == 0) ? 4'hF : ~(4'b0001 << m_idx);
                exp_seg   = model_seg(m_disp, m_idx, m_ph);
                exp_frame = ((n + 1) % FRAME == 0);
                m_in = {bus.value_i, bus.dp_i, bus.blank_i, bus.blink_i, bus.lzb_en_i};
                if (n % FRAME == FRAME - 1) m_disp = bus.load_i ? m_in : m_pend;
                if (bus.load_i) m_pend = m_in;
                n++;
            end
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("an_o", 32'(bus.an_o), 32'(exp_an));
                check("seg_o", 32'(bus.seg_o), 32'(exp_seg));
                check("frame_o", 32'(bus.frame_o), 32'(exp_frame));
            end
        end
    end

    task automatic drive(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz);
        bus.value_i = v; bus.dp_i = dp; bus.blank_i = bl; bus.blink_i = bk; bus.lzb_en_i = lz;
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                              input logic [3:0] bk, input logic lz);
        drive(v, dp, bl, bk, lz);
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
    endtask

    task automatic wait_frame();
        logic seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.frame_o === 1'b1) begin seen = 1'b1; break; end
        end
        check("frame_wait", 32'(seen), 32'd1);
    endtask

    // Wait for digit k to be lit, return its code and lit run length
    task automatic get_digit(input int k, output logic [7:0] s, output int len);
        logic [3:0] pat;
        logic       found = 1'b0;
        pat = ~(4'b0001 << k);
        s = 8'h00; len = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.an_o === pat) begin found = 1'b1; break; end
        end
        check("digit_wait", 32'(found), 32'd1);
        if (found) begin
            s = bus.seg_o; len = 1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus.an_o === pat) len++;
                else break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] s;
        logic [7:0] e [4];
        int         len;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        wait_frame();
        for (int k = 0; k < ND; k++) begin
            get_digit(k, s, len);
            check(tag, 32'(s), 32'(e[k]));
        end
    endtask

    logic [7:0] s;
    logic [7:0] bs [4];
    int         len;
    bit         ok;

    initial begin
        drive(16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        bus.load_i = 1'b0;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(bus.an_o), 32'h0000_000F);
        check("rst_seg", 32'(bus.seg_o), 32'h0000_00FF);
        check("rst_frame", 32'(bus.frame_o), 32'd0);
        rst = 1'b0;

        // Boot frame: all zeros, each digit lit 3 of 4 cycles, in order
        for (int k = 0; k < ND; k++) begin
            get_digit(k, s, len);
            check("boot_seg", 32'(s), 32'h0000_00C0);
            check("boot_len", 32'(len), 32'd3);
        end

        pulse_load(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
        check_frame("hex_12af", 8'h8E, 8'h88, 8'hA4, 8'hF9);

        pulse_load(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1);
        check_frame("lzb", 8'hC0, 8'h92, 8'hFF, 8'hFF);

        pulse_load(16'h0050, 4'b1000, 4'h0, 4'h0, 1'b1);
        check_frame("lzb_dp", 8'hC0, 8'h92, 8'hC0, 8'h40);

        // Load mid-frame at idx=2: old snapshot holds through digit 3
        wait_frame();
        get_digit(0, s, len);
        get_digit(1, s, len);
        pulse_load(16'h3333, 4'h0, 4'h0, 4'h0, 1'b0);
        get_digit(2, s, len);
        check("mid_old2", 32'(s), 32'h0000_00C0);
        get_digit(3, s, len);
        check("mid_old3", 32'(s), 32'h0000_0040);
        get_digit(0, s, len);
        check("mid_new0", 32'(s), 32'h0000_00B0);

        // Load coinciding with the commit tick
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (n % FRAME == FRAME - 1) begin ok = 1'b1; break; end
        end
        check("commit_align", 32'(ok), 32'd1);
        pulse_load(16'h4444, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k < ND; k++) begin
            get_digit(k, s, len);
            check("commit_load", 32'(s), 32'h0000_0099);
        end

        // Blink digit 0: 2 frames on, 2 frames dark
        pulse_load(16'h0007, 4'h0, 4'h0, 4'b0001, 1'b0);
        for (int f = 0; f < 4; f++) begin
            wait_frame();
            get_digit(0, bs[f], len);
            get_digit(1, s, len);
            check("blink_other", 32'(s), 32'h0000_00C0);
        end
        check("blink_val0", 32'((bs[0] == 8'hF8) || (bs[0] == 8'hFF)), 32'd1);
        check("blink_toggle02", 32'(bs[0] != bs[2]), 32'd1);
        check("blink_toggle13", 32'(bs[1] != bs[3]), 32'd1);
        check("blink_run2", 32'((bs[0] == bs[1]) || (bs[1] == bs[2])), 32'd1);

        // Asynchronous reset at idx=2, cnt=1
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (n % FRAME == 9) begin ok = 1'b1; break; end
        end
        check("rst_align", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_an", 32'(bus.an_o), 32'h0000_000F);
        check("async_seg", 32'(bus.seg_o), 32'h0000_00FF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.an_o !== 4'hF) begin ok = 1'b1; break; end
        end
        check("restart_wait", 32'(ok), 32'd1);
        check("restart_an", 32'(bus.an_o), 32'h0000_000E);
        check("restart_seg", 32'(bus.seg_o), 32'h0000_00C0);

        repeat (FRAME) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire
